// File: rtl/tx_arbiter.sv
// Round-robin frame arbiter. It merges SOURCES word streams into one FT245 transmit stream,
// prefixing each frame with a header word and preempting long frames after MAX_BURST words.
//
// state    | meaning
// S_IDLE   | no frame open; pick the next eligible source
// S_HEADER | offer header {101, cont, grant} to the output stage
// S_SEND   | pass the granted source's words straight through
module tx_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int SOURCES    = 3,
   parameter int MAX_BURST  = 256
) (
   input  logic                            clk,
   input  logic                            rst,
   output logic [DATA_WIDTH-1:0]           tx_data,
   output logic                            tx_rdy,
   input  logic                            tx_ack,
   input  logic [SOURCES*DATA_WIDTH-1:0]   src_data,
   input  logic [SOURCES-1:0]              src_rdy,
   output logic [SOURCES-1:0]              src_ack,
   input  logic [SOURCES-1:0]              src_eof,
   input  logic [SOURCES-1:0]              src_en,
   output logic [3:0]                      grant,
   output logic                            busy
);

   localparam int IW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_SEND} state_t;

   state_t               state_q, state_d;
   logic [3:0]           grant_q, grant_d;
   logic [3:0]           last_q, last_d;
   logic [SOURCES-1:0]   cont_q, cont_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 busy_q, busy_d;

   logic [IW-1:0]        sel;
   logic [IW-1:0]        idx_v;
   logic [SOURCES-1:0]   elig;
   logic                 found;
   logic [3:0]           winner;
   logic [7:0]           hdr;
   logic [DATA_WIDTH+7:0] hdr_ext;
   logic [15:0]          cnt_inc;

   assign sel = grant_q[IW-1:0];

   // Search begins one past the previous owner so every eligible source gets a turn.
   always_comb begin
      elig   = src_rdy & src_en;
      found  = 1'b0;
      winner = '0;
      idx_v  = '0;
      for (int k = 1; k <= SOURCES; k++) begin
         idx_v = IW'((int'(last_q) + k) % SOURCES);
         if (!found && elig[idx_v]) begin
            found  = 1'b1;
            winner = 4'(idx_v);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cont_d  = cont_q;
      cnt_d   = cnt_q;
      tx_rdy  = 1'b0;
      tx_data = '0;
      src_ack = '0;
      hdr     = {3'b101, cont_q[sel], grant_q};
      hdr_ext = {{DATA_WIDTH{1'b0}}, hdr};
      cnt_inc = cnt_q + 16'd1;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_HEADER;
               grant_d = winner;
            end
         end
         S_HEADER: begin
            tx_rdy  = 1'b1;
            tx_data = hdr_ext[DATA_WIDTH-1:0];
            if (tx_ack) begin
               state_d = S_SEND;
               cnt_d   = '0;
            end
         end
         S_SEND: begin
            tx_rdy       = src_rdy[sel];
            tx_data      = src_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            src_ack[sel] = tx_ack & src_rdy[sel];
            if (tx_ack && src_rdy[sel]) begin
               cnt_d = cnt_inc;
               // End of frame wins over the burst limit, so cont stays clear.
               if (src_eof[sel] || cnt_inc == 16'(MAX_BURST)) begin
                  cont_d[sel] = !src_eof[sel];
                  last_d      = grant_q;
                  grant_d     = '0;
                  state_d     = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);

      // A frame cut by reset must not consume another word in the reset cycle.
      if (rst) begin
         tx_rdy  = 1'b0;
         tx_data = '0;
         src_ack = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= 4'(SOURCES - 1);
         cont_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cont_q  <= cont_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign grant = rst ? 4'd0 : grant_q;
   assign busy  = busy_q & !rst;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: queued source words, logged output transfers,
// hand-computed expected streams per scenario.
module tb_tx_arbiter;
   localparam int DW = 8;
   localparam int NS = 3;
   localparam int MB = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DW-1:0]     tx_data;
   logic              tx_rdy;
   logic              tx_ack = 1'b1;
   logic [NS*DW-1:0]  src_data = '0;
   logic [NS-1:0]     src_rdy = '0;
   logic [NS-1:0]     src_ack;
   logic [NS-1:0]     src_eof = '0;
   logic [NS-1:0]     src_en = '1;
   logic [3:0]        grant;
   logic              busy;

   tx_arbiter #(.DATA_WIDTH(DW), .SOURCES(NS), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_ack(tx_ack),
      .src_data(src_data), .src_rdy(src_rdy), .src_ack(src_ack), .src_eof(src_eof),
      .src_en(src_en), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [8:0]    mem [NS][16];
   int            rd [NS];
   int            wr [NS];
   int            ack_cnt [NS];
   logic [NS-1:0] rdy_mask = '1;
   logic [7:0]    txlog [$];
   logic [7:0]    exp_q [$];
   int            hold_err, ack_err;
   logic          prev_pend;
   logic [7:0]    prev_data;
   logic          s_tx_rdy, s_busy;
   logic [7:0]    s_tx_data;
   logic [NS-1:0] s_src_ack;
   logic [3:0]    s_grant;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         if (rd[i] < wr[i]) begin
            src_rdy[i]          = rdy_mask[i];
            src_data[i*DW +: DW] = mem[i][rd[i]][7:0];
            src_eof[i]          = mem[i][rd[i]][8];
         end else begin
            src_rdy[i]          = 1'b0;
            src_data[i*DW +: DW] = '0;
            src_eof[i]          = 1'b0;
         end
      end
   endtask

   task automatic push(input int s, input logic [7:0] d, input logic e);
      mem[s][wr[s]] = {e, d};
      wr[s]++;
      drive();
   endtask

   // One clock: sample at the falling edge, retire consumed words just after the rising edge.
   task automatic tick();
      logic [NS-1:0] acks;
      @(negedge clk);
      s_tx_rdy  = tx_rdy;
      s_tx_data = tx_data;
      s_src_ack = src_ack;
      s_busy    = busy;
      s_grant   = grant;
      if (tx_rdy && tx_ack) txlog.push_back(tx_data);
      if (prev_pend && tx_rdy && tx_data !== prev_data) hold_err++;
      prev_pend = tx_rdy && !tx_ack;
      prev_data = tx_data;
      acks = src_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (acks[i]) begin
            ack_cnt[i]++;
            if (rd[i] < wr[i]) rd[i]++;
            else ack_err++;
         end
      end
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear();
      for (int i = 0; i < NS; i++) begin
         rd[i] = 0;
         wr[i] = 0;
         ack_cnt[i] = 0;
      end
      txlog.delete();
      hold_err  = 0;
      ack_err   = 0;
      prev_pend = 1'b0;
      rdy_mask  = '1;
      src_en    = '1;
      tx_ack    = 1'b1;
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      check("rst_tx_rdy", 32'(s_tx_rdy), 0);
      check("rst_src_ack", 32'(s_src_ack), 0);
      check("rst_busy", 32'(s_busy), 0);
      rst = 1'b0;
      tick();
      check("post_rst_tx_rdy", 32'(s_tx_rdy), 0);
      check("post_rst_tx_data", 32'(s_tx_data), 0);
      check("post_rst_busy", 32'(s_busy), 0);
      check("post_rst_grant", 32'(s_grant), 0);
   endtask

   task automatic check_log(input string tag, input logic [7:0] exp[$]);
      check({tag, "_len"}, 32'(txlog.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < txlog.size(); i++)
         check($sformatf("%s_w%0d", tag, i), 32'(txlog[i]), 32'(exp[i]));
   endtask

   initial begin
      // Single 3-word frame from source 1
      clear();
      push(1, 8'h11, 1'b0);
      push(1, 8'h22, 1'b0);
      push(1, 8'h33, 1'b1);
      do_reset();
      tick();
      check("t1_hdr_grant", 32'(s_grant), 1);
      check("t1_hdr_busy", 32'(s_busy), 1);
      check("t1_hdr_data", 32'(s_tx_data), 32'h A1);
      run(8);
      exp_q = '{8'hA1, 8'h11, 8'h22, 8'h33};
      check_log("t1", exp_q);
      check("t1_ack1", 32'(ack_cnt[1]), 3);
      check("t1_ack0", 32'(ack_cnt[0]), 0);
      check("t1_idle_busy", 32'(s_busy), 0);
      check("t1_idle_grant", 32'(s_grant), 0);

      // Round robin over three always-ready sources
      clear();
      push(0, 8'h50, 1'b1);
      push(0, 8'h51, 1'b1);
      push(1, 8'h60, 1'b1);
      push(2, 8'h70, 1'b1);
      do_reset();
      run(20);
      exp_q = '{8'hA0, 8'h50, 8'hA1, 8'h60, 8'hA2, 8'h70, 8'hA0, 8'h51};
      check_log("t2", exp_q);

      // Preemption at MAX_BURST=4, continuation header, eof coinciding with the limit
      clear();
      for (int i = 1; i <= 6; i++) push(2, 8'(i), i == 6);
      push(2, 8'h07, 1'b1);
      for (int i = 8; i <= 11; i++) push(2, 8'(i), i == 11);
      push(2, 8'h0C, 1'b1);
      do_reset();
      run(40);
      exp_q = '{8'hA2, 8'h01, 8'h02, 8'h03, 8'h04, 8'hB2, 8'h05, 8'h06,
                8'hA2, 8'h07, 8'hA2, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'hA2, 8'h0C};
      check_log("t3", exp_q);
      check("t3_ack2", 32'(ack_cnt[2]), 12);

      // tx_ack toggling: words held until accepted
      clear();
      push(0, 8'h31, 1'b0);
      push(0, 8'h32, 1'b0);
      push(0, 8'h33, 1'b1);
      do_reset();
      for (int k = 0; k < 16; k++) begin
         tx_ack = k[0];
         tick();
      end
      tx_ack = 1'b1;
      exp_q = '{8'hA0, 8'h31, 8'h32, 8'h33};
      check_log("t4", exp_q);
      check("t4_hold", 32'(hold_err), 0);
      check("t4_ack_err", 32'(ack_err), 0);

      // src_rdy and src_en dropped mid-frame: frame stalls, then completes
      clear();
      push(0, 8'h41, 1'b0);
      push(0, 8'h42, 1'b0);
      push(0, 8'h43, 1'b1);
      do_reset();
      run(2);
      src_en[0]   = 1'b0;
      rdy_mask[0] = 1'b0;
      drive();
      tick();
      check("t4b_stall_rdy", 32'(s_tx_rdy), 0);
      check("t4b_stall_busy", 32'(s_busy), 1);
      check("t4b_stall_ack", 32'(s_src_ack), 0);
      tick();
      rdy_mask[0] = 1'b1;
      drive();
      run(6);
      exp_q = '{8'hA0, 8'h41, 8'h42, 8'h43};
      check_log("t4b", exp_q);

      // Disabled source never granted
      clear();
      src_en[0] = 1'b0;
      push(0, 8'h90, 1'b1);
      push(1, 8'h91, 1'b1);
      do_reset();
      run(12);
      exp_q = '{8'hA1, 8'h91};
      check_log("t5", exp_q);
      check("t5_ack0", 32'(ack_cnt[0]), 0);
      check("t5_ack1", 32'(ack_cnt[1]), 1);

      // Reset after the second payload word
      clear();
      src_en[0] = 1'b0;
      for (int i = 1; i <= 5; i++) push(2, 8'hC0 + 8'(i), i == 5);
      do_reset();
      run(3);
      rst = 1'b1;
      tick();
      check("t6_rst_tx_rdy", 32'(s_tx_rdy), 0);
      check("t6_rst_ack", 32'(s_src_ack), 0);
      push(0, 8'hD0, 1'b1);
      src_en = '1;
      drive();
      rst = 1'b0;
      tick();
      check("t6_post_tx_rdy", 32'(s_tx_rdy), 0);
      run(20);
      exp_q = '{8'hA2, 8'hC1, 8'hC2, 8'hA0, 8'hD0, 8'hA2, 8'hC3, 8'hC4, 8'hC5};
      check_log("t6", exp_q);
      check("t6_ack2", 32'(ack_cnt[2]), 5);
      check("t6_ack_err", 32'(ack_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
